seq_bit_serializer: RTL and testbench

- Upstream feeder for the serial sequence detector: accepts parallel words over a valid/ready handshake and emits them MSB-first, one bit per clk, on the detector's serial input x.
- Double-buffered (hold register plus shift register), so consecutive words stream with no idle cycles between them.
- Drives 0 on x_out when idle. The detector treats this as a non-matching bit stream.

---
 rtl/seq_bit_serializer_if.sv | 44 ++++
 rtl/seq_bit_serializer.sv | 120 ++++++++++++
 tb/tb_seq_bit_serializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_bit_serializer_if.sv
// Handshake and serial-output bundle for seq_bit_serializer.
//
// Signals:
//   in_data   parallel word from the source
//   in_valid  source has a word on in_data
//   in_ready  serializer can take a word (hold register empty)
//   x_out     serial bit to the detector's x input, MSB first
//   x_valid   x_out carries a data (or parity) bit
//   last_bit  final bit cycle of the current word
//   busy      a word is being shifted or is waiting in the hold register
//
// Modports: master = word source / bit sink (testbench or parent),
//           slave  = the serializer itself.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x_out;
    logic             x_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  x_out,
        input  x_valid,
        input  last_bit,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output x_out,
        output x_valid,
        output last_bit,
        output busy
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the serial sequence detector.
//
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them out
// MSB first, one bit per clk, on x_out. A hold register sits in front of the
// shift register so the next word is loaded on the final bit edge of the
// current one, giving a gapless stream. x_out is 0 whenever idle.
//
// Optional feature: define SEQ_SER_PARITY_EN to append one even-parity bit
// (XOR of the word) after each word; a word then takes WIDTH+1 bit cycles.
//
// Ports:
//   clk  clock, rising edge
//   clr  asynchronous active-high reset
//   bus  seq_bit_serializer_if.slave (in_data/in_valid/in_ready handshake,
//        x_out/x_valid/last_bit/busy serial side)
//
// Parameters:
//   WIDTH  word width, 2..32
//   CNT_W  bit counter width, derived from WIDTH; leave at default
module seq_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                clk,
    input logic                clr,
    seq_bit_serializer_if.slave bus
);

`ifdef SEQ_SER_PARITY_EN
    // Parity occupies the cycle after bit WIDTH-1.
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             hold_full;
`ifdef SEQ_SER_PARITY_EN
    logic             parity_reg;
`endif

    logic accept;
    logic at_last;

    // in_ready is ~hold_full, so an accept and a drain never share an edge.
    assign accept  = bus.in_valid & ~hold_full;
    assign at_last = (state == StShift) && (bit_cnt == LastCnt);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= StIdle;
            shift_reg <= '0;
            hold_reg  <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            if (accept) begin
                hold_reg  <= bus.in_data;
                hold_full <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (hold_full) begin
                        shift_reg <= hold_reg;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= StShift;
`ifdef SEQ_SER_PARITY_EN
                        parity_reg <= ^hold_reg;
`endif
                    end
                end
                StShift: begin
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (at_last) begin
                        if (hold_full) begin
                            // Chain the held word with no gap cycle.
                            shift_reg <= hold_reg;
                            hold_full <= 1'b0;
                            bit_cnt   <= '0;
`ifdef SEQ_SER_PARITY_EN
                            parity_reg <= ^hold_reg;
`endif
                        end else begin
                            bit_cnt <= '0;
                            state   <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    // All outputs decode directly from registers; reset clears them at once.
    assign bus.in_ready = ~hold_full;
    assign bus.x_valid  = (state == StShift);
    assign bus.last_bit = at_last;
    assign bus.busy     = (state == StShift) | hold_full;

`ifdef SEQ_SER_PARITY_EN
    assign bus.x_out = (state == StShift) &
                       ((bit_cnt == LastCnt) ? parity_reg : shift_reg[WIDTH-1]);
`else
    assign bus.x_out = (state == StShift) & shift_reg[WIDTH-1];
`endif

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer. A queue-based reference model
// turns every accepted word into its expected bit sequence (MSB first, plus a
// parity bit when SEQ_SER_PARITY_EN is defined); each valid output cycle pops
// and compares. Directed steps cover latency, chaining, backpressure, reset
// mid-word and idle, followed by a randomized stream.
module tb_seq_bit_serializer;
    localparam int WIDTH = 8;
`ifdef SEQ_SER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    seq_bit_serializer_if #(.WIDTH(WIDTH)) bus ();

    seq_bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    bit   exp_bit[$];
    bit   exp_last[$];
    logic s_xv, s_rdy, s_busy;
    logic prev_xv = 1'b0;
    bit   acc;
    int   vcnt, rises;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: expected serial image of one accepted word.
    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            exp_bit.push_back(w[i]);
`ifdef SEQ_SER_PARITY_EN
            exp_last.push_back(1'b0);
`else
            exp_last.push_back(i == 0);
`endif
        end
`ifdef SEQ_SER_PARITY_EN
        exp_bit.push_back(^w);
        exp_last.push_back(1'b1);
`endif
    endtask

    // One clock cycle: sample/check at negedge, then return 1 ns after posedge.
    task automatic cyc();
        bit b, l;
        @(negedge clk);
        s_xv   = bus.x_valid;
        s_rdy  = bus.in_ready;
        s_busy = bus.busy;
        if (bus.x_valid) begin
            if (exp_bit.size() == 0) begin
                chk("extra_bit", 32'(bus.x_valid), 32'd0);
            end else begin
                b = exp_bit.pop_front();
                l = exp_last.pop_front();
                chk("x_out", 32'(bus.x_out), 32'(b));
                chk("last_bit", 32'(bus.last_bit), 32'(l));
            end
        end else begin
            chk("idle_x_out", 32'(bus.x_out), 32'd0);
            chk("idle_last", 32'(bus.last_bit), 32'd0);
        end
        if (bus.x_valid && !prev_xv) rises++;
        if (bus.x_valid) vcnt++;
        prev_xv = bus.x_valid;
        acc = bus.in_valid && bus.in_ready;
        if (acc) push_word(bus.in_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        clr          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_x_out", 32'(bus.x_out), 32'd0);
        chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
        chk("rst_last_bit", 32'(bus.last_bit), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        cyc();
        cyc();

        // Single word: MSB appears the cycle after the load edge.
        bus.in_data  = 8'hA8;
        bus.in_valid = 1'b1;
        cyc();
        chk("t1_accept", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        for (int k = 0; k <= NB + 2; k++) begin
            cyc();
            chk("t1_x_valid", 32'(s_xv), 32'(k >= 1 && k <= NB));
            chk("t1_busy", 32'(s_busy), 32'(k <= NB));
        end
        chk("t1_drained", 32'(exp_bit.size()), 32'd0);

        // Back-to-back words with in_valid held high.
        vcnt         = 0;
        rises        = 0;
        n            = 0;
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && n < 2; i++) begin
            cyc();
            if (acc) begin
                n++;
                bus.in_data = 8'h55;
            end
        end
        bus.in_valid = 1'b0;
        chk("t2_accepts", 32'(n), 32'd2);
        cyc();
        chk("t2_rdy_after_2nd", 32'(s_rdy), 32'd0);
        for (int i = 0; i < 2 * NB + 4; i++) cyc();
        chk("t2_bit_cycles", 32'(vcnt), 32'(2 * NB));
        chk("t2_one_run", 32'(rises), 32'd1);
        chk("t2_drained", 32'(exp_bit.size()), 32'd0);

        // Backpressure: pending word must survive in_data churn.
        vcnt         = 0;
        rises        = 0;
        n            = 0;
        bus.in_data  = 8'hF0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && n < 2; i++) begin
            cyc();
            if (acc) begin
                n++;
                bus.in_data = 8'h0F;
            end
        end
        chk("t3_accepts", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            bus.in_data = WIDTH'($urandom);
            cyc();
            chk("t3_rdy_low", 32'(s_rdy), 32'd0);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2 * NB + 4; i++) cyc();
        chk("t3_bit_cycles", 32'(vcnt), 32'(2 * NB));
        chk("t3_one_run", 32'(rises), 32'd1);
        chk("t3_drained", 32'(exp_bit.size()), 32'd0);

        // Reset during the 4th bit of a word with another word held.
        n            = 0;
        seen         = 0;
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && n < 2; i++) begin
            cyc();
            if (acc) begin
                n++;
                bus.in_data = 8'h5A;
            end
        end
        bus.in_valid = 1'b0;
        chk("t4_accepts", 32'(n), 32'd2);
        for (int i = 0; i < 20 && seen < 3; i++) begin
            cyc();
            if (s_xv) seen++;
        end
        chk("t4_reach_bit4", 32'(seen), 32'd3);
        #2;
        clr = 1'b1;
        #1;
        chk("t4_x_out", 32'(bus.x_out), 32'd0);
        chk("t4_x_valid", 32'(bus.x_valid), 32'd0);
        chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        chk("t4_last_bit", 32'(bus.last_bit), 32'd0);
        exp_bit.delete();
        exp_last.delete();
        @(posedge clk);
        #1;
        clr  = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 12; i++) cyc();
        chk("t4_no_bits", 32'(vcnt), 32'd0);

        // Idle input.
        for (int i = 0; i < 20; i++) begin
            bus.in_data = WIDTH'($urandom);
            cyc();
            chk("t5_x_valid", 32'(s_xv), 32'd0);
            chk("t5_in_ready", 32'(s_rdy), 32'd1);
        end

        // Randomized stream against the queue model.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            cyc();
            if (acc || $urandom_range(0, 1) == 1) bus.in_data = WIDTH'($urandom);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3 * NB && (exp_bit.size() != 0 || s_busy); i++) cyc();
        chk("rand_drained", 32'(exp_bit.size()), 32'd0);
        chk("rand_idle_busy", 32'(s_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
